// File: rtl/blur_feeder_pkg.sv
// blur_feeder_pkg: shared state encoding and defaults for the blur pixel feeder
package blur_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} feeder_state_t;
  localparam int PRIME_LINES_DEF = 4;
endpackage

// File: rtl/line_credit_counter.sv
// line_credit_counter: saturating up/down row-credit counter with load and next-zero lookahead
module line_credit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zeroNext
);
  logic [W-1:0] count_q, count_d;
  // load wins; simultaneous inc and dec cancel; saturate at both ends
  always_comb begin
    count_d = load ? loadVal :
              (inc && !dec && !(&count_q)) ? count_q + 1'b1 :
              (dec && !inc && (|count_q)) ? count_q - 1'b1 : count_q;
    zeroNext = count_d == '0;
  end
  // credit register
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/blur_pixel_feeder.sv
// blur_pixel_feeder: raster-order pixel source that primes and then paces the box blur core
module blur_pixel_feeder
  import blur_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int ADDR_WIDTH  = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int PRIME_LINES = PRIME_LINES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  memRdEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memRdData,
  input  logic                  lineDone,
  output logic [DATA_WIDTH-1:0] outPixel,
  output logic                  outPixelValid,
  output logic                  busy,
  output logic                  done
);
  localparam int CW   = $clog2(PRIME_LINES + IMG_HEIGHT) + 1;
  localparam int COLW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int ROWW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  feeder_state_t state_q, state_d;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic rd_en_q, valid_q, busy_q, done_q;
  logic [CW-1:0] credit;
  logic credit_zero_next, row_end, last_row;
  assign row_end  = state_q == SEND && col_q == COLW'(IMG_WIDTH - 1);
  assign last_row = row_q == ROWW'(IMG_HEIGHT - 1);
  line_credit_counter #(.W(CW)) u_credit (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == IDLE && start),
    .loadVal  (CW'(PRIME_LINES)),
    .inc      (lineDone && state_q != IDLE),
    .dec      (row_end),
    .count    (credit),
    .zeroNext (credit_zero_next)
  );
  // next state and raster counters; the address runs linearly since rows are read in order
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (start) begin
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        addr_d  = addr_q + 1'b1;
        col_d   = row_end ? '0 : col_q + 1'b1;
        row_d   = row_end ? row_q + 1'b1 : row_q;
        state_d = (row_end && last_row) ? FINISH : (row_end && credit_zero_next) ? WAIT : SEND;
      end
      WAIT: state_d = credit != '0 ? SEND : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and registered outputs derived from the upcoming state
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      rd_en_q <= state_d == SEND;
      valid_q <= rd_en_q;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == FINISH;
    end
  assign memRdEn       = rd_en_q;
  assign memAddr       = addr_q;
  assign outPixelValid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign outPixel      = valid_q ? memRdData : '0;
endmodule
